// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state encoding, command opcodes, driver FSM states
// and the IEEE 1149.1 TAP transition function.
package jtag_pkg;

  localparam logic [4:0] TAP_TEST_LOGIC_RESET = 5'h00;
  localparam logic [4:0] TAP_RUN_TEST_IDLE    = 5'h01;
  localparam logic [4:0] TAP_SELECT_DR        = 5'h02;
  localparam logic [4:0] TAP_SELECT_IR        = 5'h03;
  localparam logic [4:0] TAP_CAPTURE_DR       = 5'h04;
  localparam logic [4:0] TAP_CAPTURE_IR       = 5'h05;
  localparam logic [4:0] TAP_SHIFT_DR         = 5'h06;
  localparam logic [4:0] TAP_SHIFT_IR         = 5'h07;
  localparam logic [4:0] TAP_EXIT1_DR         = 5'h08;
  localparam logic [4:0] TAP_EXIT1_IR         = 5'h09;
  localparam logic [4:0] TAP_PAUSE_DR         = 5'h10;
  localparam logic [4:0] TAP_PAUSE_IR         = 5'h11;
  localparam logic [4:0] TAP_EXIT2_DR         = 5'h12;
  localparam logic [4:0] TAP_EXIT2_IR         = 5'h13;
  localparam logic [4:0] TAP_UPDATE_DR        = 5'h14;
  localparam logic [4:0] TAP_UPDATE_IR        = 5'h15;

  localparam logic [1:0] OP_RESET   = 2'd0;
  localparam logic [1:0] OP_IDLE    = 2'd1;
  localparam logic [1:0] OP_SCAN_IR = 2'd2;
  localparam logic [1:0] OP_SCAN_DR = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_READY,
    ST_SEQ,
    ST_SHIFT,
    ST_IDLE_WAIT
  } drv_state_t;

  function automatic logic [4:0] tap_next(input logic [4:0] state, input logic tms);
    logic [4:0] nxt;
    nxt = TAP_TEST_LOGIC_RESET;
    case (state)
      TAP_TEST_LOGIC_RESET: nxt = tms ? TAP_TEST_LOGIC_RESET : TAP_RUN_TEST_IDLE;
      TAP_RUN_TEST_IDLE:    nxt = tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
      TAP_SELECT_DR:        nxt = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_SELECT_IR:        nxt = tms ? TAP_TEST_LOGIC_RESET : TAP_CAPTURE_IR;
      TAP_CAPTURE_DR:       nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_SHIFT_DR:         nxt = tms ? TAP_EXIT1_DR : TAP_SHIFT_DR;
      TAP_EXIT1_DR:         nxt = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:         nxt = tms ? TAP_EXIT2_DR : TAP_PAUSE_DR;
      TAP_EXIT2_DR:         nxt = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:        nxt = tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
      TAP_CAPTURE_IR:       nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_SHIFT_IR:         nxt = tms ? TAP_EXIT1_IR : TAP_SHIFT_IR;
      TAP_EXIT1_IR:         nxt = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:         nxt = tms ? TAP_EXIT2_IR : TAP_PAUSE_IR;
      TAP_EXIT2_IR:         nxt = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:        nxt = tms ? TAP_SELECT_DR : TAP_RUN_TEST_IDLE;
      default:              nxt = TAP_TEST_LOGIC_RESET;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/jtag_tap_mirror.sv
// Registered copy of the TAP state, advanced each tck edge from the tms being presented.
// One-cycle latency, no backpressure.
module jtag_tap_mirror
  import jtag_pkg::*;
(
  input  logic       tck,
  input  logic       trst_n,
  input  logic       tms,
  output logic [4:0] tap_state
);

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) tap_state <= TAP_TEST_LOGIC_RESET;
    else         tap_state <= tap_next(tap_state, tms);
  end

endmodule

// File: rtl/jtag_driver.sv
// Turns RESET/IDLE/SCAN commands into registered TMS/TDI sequences and collects TDO.
// First tms bit one cycle after accept; cmd_ready low while a command runs, busy offers dropped.
module jtag_driver
  import jtag_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               tck,
  input  logic               trst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tms,
  output logic               tdi,
  input  logic               tdo,
  output logic [4:0]         tap_state
);

  drv_state_t         state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d, len_q, len_d;
  logic [LEN_W-1:0]   cmd_n, cnt_inc, len_m1;
  logic [MAX_LEN-1:0] data_q, data_d, cap_q, cap_d, bit_mask;
  logic [5:0]         pat_q, pat_d;
  logic               scan_q, scan_d, post_q, post_d;
  logic               tms_d, tdi_d, ready_d, rsp_valid_d;
  logic [MAX_LEN-1:0] rsp_data_d;
  logic               accept, seq_end, shift_end, idle_end;

  assign accept    = cmd_valid && cmd_ready;
  assign cnt_inc   = cnt_q + LEN_W'(1);
  assign len_m1    = len_q - LEN_W'(1);
  assign seq_end   = (cnt_q == '0);
  assign shift_end = (cnt_q == len_m1);
  assign idle_end  = (cnt_inc >= len_q);
  assign bit_mask  = {{(MAX_LEN-1){1'b0}}, 1'b1} << cnt_q;

  // Scan length clamped to 1..MAX_LEN
  always_comb begin
    cmd_n = cmd_len;
    if (cmd_len == '0)                    cmd_n = LEN_W'(1);
    else if (cmd_len > LEN_W'(MAX_LEN))   cmd_n = LEN_W'(MAX_LEN);
  end

  always_ff @(posedge tck or negedge trst_n) begin
    if (!trst_n) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      len_q     <= '0;
      data_q    <= '0;
      cap_q     <= '0;
      pat_q     <= '0;
      scan_q    <= 1'b0;
      post_q    <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      data_q    <= data_d;
      cap_q     <= cap_d;
      pat_q     <= pat_d;
      scan_q    <= scan_d;
      post_q    <= post_d;
      tms       <= tms_d;
      tdi       <= tdi_d;
      cmd_ready <= ready_d;
      rsp_valid <= rsp_valid_d;
      rsp_data  <= rsp_data_d;
    end
  end

  // In SEQ, cnt_q counts the tms bits still to present and pat_q holds them LSB first.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    data_d  = data_q;
    cap_d   = cap_q;
    pat_d   = pat_q;
    scan_d  = scan_q;
    post_d  = post_q;
    case (state_q)
      ST_INIT: begin
        cnt_d = cnt_inc;
        if (cnt_q == LEN_W'(5)) begin
          state_d = ST_READY;
          cnt_d   = '0;
        end
      end
      ST_READY: begin
        if (accept) begin
          data_d = cmd_data;
          cap_d  = '0;
          post_d = 1'b0;
          scan_d = cmd_op[1];
          len_d  = cmd_n;
          case (cmd_op)
            OP_RESET: begin
              state_d = ST_SEQ;
              pat_d   = 6'b001111;
              cnt_d   = LEN_W'(5);
            end
            OP_IDLE: begin
              state_d = ST_IDLE_WAIT;
              cnt_d   = '0;
              len_d   = cmd_len;
            end
            OP_SCAN_IR: begin
              state_d = ST_SEQ;
              pat_d   = 6'b000001;
              cnt_d   = LEN_W'(3);
            end
            default: begin
              state_d = ST_SEQ;
              pat_d   = 6'b000000;
              cnt_d   = LEN_W'(2);
            end
          endcase
        end
      end
      ST_SEQ: begin
        if (!seq_end) begin
          pat_d = pat_q >> 1;
          cnt_d = cnt_q - LEN_W'(1);
        end else if (scan_q && !post_q) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_SHIFT: begin
        cap_d  = tdo ? (cap_q | bit_mask) : cap_q;
        data_d = data_q >> 1;
        if (shift_end) begin
          // Exit1 reached; one remaining tms=0 after Update returns to Run-Test/Idle
          state_d = ST_SEQ;
          post_d  = 1'b1;
          pat_d   = '0;
          cnt_d   = LEN_W'(1);
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_IDLE_WAIT: begin
        if (idle_end) state_d = ST_READY;
        else          cnt_d   = cnt_inc;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    ready_d     = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data;
    case (state_q)
      ST_INIT: begin
        tms_d   = (cnt_q < LEN_W'(4));
        ready_d = (cnt_q == LEN_W'(5));
      end
      ST_READY: begin
        ready_d = !accept;
        tms_d   = accept && (cmd_op != OP_IDLE);
      end
      ST_SEQ: begin
        if (!seq_end) begin
          tms_d = pat_q[0];
        end else if (scan_q && !post_q) begin
          tms_d = (len_q == LEN_W'(1));
          tdi_d = data_q[0];
        end else begin
          ready_d     = 1'b1;
          rsp_valid_d = post_q;
          if (post_q) rsp_data_d = cap_q;
        end
      end
      ST_SHIFT: begin
        if (shift_end) begin
          tms_d = 1'b1;
        end else begin
          tms_d = (cnt_inc == len_m1);
          tdi_d = data_q[1];
        end
      end
      ST_IDLE_WAIT: ready_d = idle_end;
      default: ;
    endcase
  end

  jtag_tap_mirror u_tap_mirror (
    .tck       (tck),
    .trst_n    (trst_n),
    .tms       (tms),
    .tap_state (tap_state)
  );

endmodule

// File: tb/tb_jtag_driver.sv
// Scoreboard bench for jtag_driver: per-cycle tms/tdi/ready expectations, response queue,
// and an independent TAP model checked against tap_state every cycle.
module tb_jtag_driver;

  localparam int MAX_LEN = 32;
  localparam int LEN_W   = 6;

  logic              tck = 1'b0;
  logic              trst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [1:0]        cmd_op = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [31:0]       cmd_data = '0;
  logic              cmd_ready, rsp_valid, tms, tdi, tdo;
  logic [31:0]       rsp_data;
  logic [4:0]        tap_state;
  logic [1:0]        tdo_mode = 2'd0;
  logic [4:0]        tap_ref;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic rdy;
    logic rv;
    logic tms;
    logic tdi;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rsp_q[$];
  exp_t        mon_e;

  always #5 tck = ~tck;
  always @(posedge tck) cyc <= cyc + 1;

  // Bench-side TAP: loopback, inverted loopback, or constant tdo
  assign tdo = (tdo_mode == 2'd0) ? tdi :
               (tdo_mode == 2'd1) ? ~tdi :
               (tdo_mode == 2'd2);

  jtag_driver #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .tck       (tck),
    .trst_n    (trst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .tms       (tms),
    .tdi       (tdi),
    .tdo       (tdo),
    .tap_state (tap_state)
  );

  function automatic logic [4:0] ref_step(input logic [4:0] s, input logic m);
    case (s)
      5'h00:        return m ? 5'h00 : 5'h01;
      5'h01:        return m ? 5'h02 : 5'h01;
      5'h02:        return m ? 5'h03 : 5'h04;
      5'h03:        return m ? 5'h00 : 5'h05;
      5'h04, 5'h06: return m ? 5'h08 : 5'h06;
      5'h05, 5'h07: return m ? 5'h09 : 5'h07;
      5'h08:        return m ? 5'h14 : 5'h10;
      5'h09:        return m ? 5'h15 : 5'h11;
      5'h10:        return m ? 5'h12 : 5'h10;
      5'h11:        return m ? 5'h13 : 5'h11;
      5'h12:        return m ? 5'h14 : 5'h06;
      5'h13:        return m ? 5'h15 : 5'h07;
      5'h14, 5'h15: return m ? 5'h02 : 5'h01;
      default:      return 5'h00;
    endcase
  endfunction

  always @(posedge tck or negedge trst_n) begin
    if (!trst_n) tap_ref <= 5'h00;
    else         tap_ref <= ref_step(tap_ref, tms);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic r, input logic v, input logic t, input logic d);
    return {r, v, t, d};
  endfunction

  function automatic logic tdo_bit(input logic [1:0] m, input logic b);
    case (m)
      2'd0:    return b;
      2'd1:    return ~b;
      2'd2:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always @(negedge tck) begin
    if (trst_n) begin
      check("tap_state", {27'b0, tap_state}, {27'b0, tap_ref});
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("cmd_ready", {31'b0, cmd_ready}, {31'b0, mon_e.rdy});
        check("rsp_valid", {31'b0, rsp_valid}, {31'b0, mon_e.rv});
        check("tms", {31'b0, tms}, {31'b0, mon_e.tms});
        check("tdi", {31'b0, tdi}, {31'b0, mon_e.tdi});
      end else begin
        check("idle cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("idle tms", {31'b0, tms}, 32'd0);
        check("idle tap_state", {27'b0, tap_state}, 32'h01);
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check("spurious rsp_valid", {31'b0, rsp_valid}, 32'd0);
        else                   check("rsp_data", rsp_data, rsp_q.pop_front());
      end
    end
  end

  // Expected per-cycle behaviour from the command's TMS recipe
  task automatic push_cmd(input logic [1:0] op, input logic [5:0] len,
                          input logic [31:0] data, input logic [1:0] mode);
    int n;
    logic [31:0] r;
    r = '0;
    case (op)
      2'd0: for (int i = 0; i < 6; i++) exp_q.push_back(mk(1'b0, 1'b0, i < 5, 1'b0));
      2'd1: begin
        n = (len == 0) ? 1 : int'(len);
        repeat (n) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
      end
      default: begin
        n = (len == 0) ? 1 : (len > 32) ? 32 : int'(len);
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        if (op == 2'd2) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        for (int i = 0; i < n; i++) begin
          exp_q.push_back(mk(1'b0, 1'b0, i == n - 1, data[i]));
          r[i] = tdo_bit(mode, data[i]);
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
        rsp_q.push_back(r);
      end
    endcase
    exp_q.push_back(mk(1'b1, op[1], 1'b0, 1'b0));
  endtask

  task automatic issue(input logic [1:0] op, input logic [5:0] len,
                       input logic [31:0] data, input logic [1:0] mode);
    int waited;
    waited = 0;
    @(negedge tck);
    while (!cmd_ready && waited < 200) begin
      // offers while busy must be dropped
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_op    = 2'($urandom);
      cmd_len   = 6'($urandom);
      cmd_data  = $urandom;
      @(negedge tck);
      waited++;
    end
    check("cmd_ready wait", {31'b0, cmd_ready}, 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    tdo_mode  = mode;
    @(posedge tck);
    #1 cmd_valid = 1'b0;
    push_cmd(op, len, data, mode);
  endtask

  task automatic check_reset_vals();
    check("reset tms", {31'b0, tms}, 32'd1);
    check("reset tdi", {31'b0, tdi}, 32'd0);
    check("reset cmd_ready", {31'b0, cmd_ready}, 32'd0);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset tap_state", {27'b0, tap_state}, 32'h00);
  endtask

  task automatic reset_release();
    @(posedge tck);
    #2 trst_n = 1'b1;
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    int w;
    logic [1:0] op;
    #23;
    check_reset_vals();
    reset_release();

    issue(2'd3, 6'd8, 32'h0000_00A5, 2'd0);
    issue(2'd2, 6'd4, 32'h0000_0003, 2'd2);
    issue(2'd3, 6'd0, $urandom, 2'd0);
    issue(2'd2, 6'd40, $urandom, 2'd1);
    issue(2'd1, 6'd0, 32'd0, 2'd0);
    issue(2'd1, 6'd5, 32'd0, 2'd0);
    issue(2'd0, 6'd0, 32'd0, 2'd0);

    // reset during the third shift bit of a 16-bit DR scan
    issue(2'd3, 6'd16, 32'h1234_5678, 2'd0);
    repeat (6) @(negedge tck);
    #1 trst_n = 1'b0;
    exp_q.delete();
    rsp_q.delete();
    #1 check_reset_vals();
    reset_release();
    issue(2'd3, 6'd16, 32'hCAFE_F00D, 2'd1);

    while (cyc < 10000) begin
      repeat ($urandom_range(0, 2)) @(negedge tck);
      op = 2'($urandom);
      issue(op, (op == 2'd1) ? 6'($urandom_range(0, 12)) : 6'($urandom_range(0, 40)),
            $urandom, 2'($urandom));
    end

    w = 0;
    while (exp_q.size() > 0 && w < 200) begin
      @(negedge tck);
      w++;
    end
    check("expectations drained", exp_q.size(), 32'd0);
    check("responses drained", rsp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jtag_driver.md
# jtag_driver

Host-side JTAG driver that turns simple scan commands into TMS/TDI bit sequences for a TAP controller and collects the TDO bits shifted back. It sits between an on-chip command source (bring-up sequencer, test bench, debug bridge) and the TAP. It tracks the TAP state internally, so the TAP state machine can be exercised and checked cycle by cycle.

## Interface
Parameters:
- MAX_LEN, 32: maximum scan length in bits; width of scan data buses.
- LEN_W, 6: width of cmd_len; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- tck  in  1  JTAG clock; the driver and the TAP both act on posedge.
- trst_n  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  driver idle in Run-Test/Idle and able to accept a command.
- cmd_op  in  2  0=RESET, 1=IDLE, 2=SCAN_IR, 3=SCAN_DR.
- cmd_len  in  LEN_W  scan bit count, or idle cycle count.
- cmd_data  in  MAX_LEN  TDI bits, LSB shifted first.
- rsp_valid  out  1  one-cycle pulse when a scan completes.
- rsp_data  out  MAX_LEN  captured TDO bits, right-justified, first bit in bit 0.
- tms  out  1  to the TAP.
- tdi  out  1  to the TAP.
- tdo  in  1  from the TAP.
- tap_state  out  5  mirrored TAP state, using the shared TAP encoding.

## Operation
- All outputs are registered. The TAP samples the tms/tdi values presented in cycle k at the posedge ending cycle k.
- Reset values:
  - tms=1, tdi=0.
  - cmd_ready=0, rsp_valid=0, rsp_data=0.
  - tap_state=TestLogicReset (0x00).
  - internal FSM=INIT.
- INIT sequence after reset release:
  - Drive tms=1 for 5 cycles, then tms=0 for 1 cycle. This lands the TAP in RunTestOrIdle (0x01).
  - cmd_ready rises in the next cycle.
- A command is accepted when cmd_valid && cmd_ready. cmd_op, cmd_len and cmd_data are latched on acceptance. cmd_ready stays low until the command finishes.
- TMS sequences, all starting and ending in RunTestOrIdle:
  - RESET: 1,1,1,1,1,0. 6 cycles. No response.
  - IDLE: N cycles of tms=0, with N=cmd_len. N=0 finishes immediately: cmd_ready low for exactly 1 cycle.
  - SCAN_DR: 1,0,0, then N shift cycles, then 1,0. N+5 cycles.
    - Shift cycles: tms=0 except the last bit, which has tms=1.
    - tdi=cmd_data[i] on shift cycle i.
  - SCAN_IR: 1,1,0,0, then N shift cycles, then 1,0. N+6 cycles.
- Scan length: N=cmd_len, clamped to the range 1..MAX_LEN (0→1, >MAX_LEN→MAX_LEN).
- TDO capture: tdo is sampled at the posedge ending shift cycle i and stored in rsp_data[i]. Bits at index ≥N read 0.
- tdi is 0 outside shift cycles.
- tap_state is updated every posedge using the standard TAP transition function applied to the tms being presented. It always equals the TAP's state.
- Internal FSM states: INIT, READY, SEQ (walks the TMS pre/post-amble), SHIFT, IDLE_WAIT.
- rsp_data holds its value until the next scan completes. rsp_valid does not pulse for RESET or IDLE commands.

## Timing
- Command accepted at edge E. The first tms bit of the sequence is presented in cycle E+1.
- cmd_ready and rsp_valid both assert in the cycle after the final tms=0 bit.
- Back-to-back commands: a command can be accepted in the same cycle that rsp_valid is high.
- cmd_valid while busy is ignored, not queued.
- trst_n low at any time, including mid-scan:
  - All outputs return to their reset values immediately (asynchronous).
  - A partial rsp_data is discarded.
  - INIT restarts on release.
- tms is never 1 for five consecutive cycles except during INIT and RESET.

## Structure
- Package jtag_pkg holds:
  - the 5-bit TAP state localparams (TestLogicReset=0x00 … UpdateIr=0x15);
  - the command opcode constants;
  - a pure function tap_next(state, tms).
- The TAP controller should also import jtag_pkg.
- Sub-module jtag_tap_mirror: a registered tap_state tracker driven by tms, clocked on tck and reset by trst_n.
- The command FSM and the shift/capture datapath stay in jtag_driver.

## Test plan
- Reset release → 5 cycles tms=1 then 1 cycle tms=0; cmd_ready=1 on cycle 7; tap_state=0x01.
- SCAN_DR, len=8, data=0xA5; TAP loopback tdo=tdi → tdi bits 1,0,1,0,0,1,0,1; cmd_ready low for 13 cycles; rsp_valid pulse; rsp_data=0xA5.
- SCAN_IR, len=4, data=0x3, tdo tied 1 → 10-cycle sequence; tap_state passes 0x03, 0x05, 0x07, 0x09, 0x15; rsp_data=0xF.
- Connect to the TAP controller, random legal commands for 10k cycles → tap_state equals TAP current_state every cycle; each scan ends in 0x01.
- trst_n pulsed during the 3rd shift bit of a 16-bit scan → outputs at reset values immediately; no rsp_valid; INIT reruns; the next scan is correct.
- Length edges: len=0 and len=40 scans run 1 and 32 shift bits respectively; IDLE len=0 → cmd_ready low for exactly 1 cycle.
